// File: rtl/draw_pkg.sv
// Shared types and constants for the Bresenham line-drawing custom instruction.
package draw_pkg;

    // Sequencer states of the line walker.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PLOT,
        STEP,
        FINISH
    } state_t;

    // Custom-instruction opcodes carried on the n input.
    localparam logic OP_SET_COLOR = 1'b0;
    localparam logic OP_DRAW      = 1'b1;

    // Default visible resolution.
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Signed screen coordinate pair.
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } point_t;

    // Operand word layout is {y[31:16], x[15:0]}.
    function automatic point_t to_point(input logic [31:0] word);
        point_t p;
        p.x = word[15:0];
        p.y = word[31:16];
        return p;
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: next position and error term from the current ones.
module bresenham_step
    import draw_pkg::*;
(
    input  point_t             cur,
    input  logic signed [17:0] err,
    input  logic signed [17:0] dx,
    input  logic signed [17:0] dy,
    input  logic               sx,     // 1: step +1 in x, 0: step -1
    input  logic               sy,     // 1: step +1 in y, 0: step -1
    output point_t             nxt_pt,
    output logic signed [17:0] nxt_err
);

    logic signed [17:0] e2;

    // Both axis tests use the error value from before this step.
    always_comb begin
        e2      = err <<< 1;
        nxt_pt  = cur;
        nxt_err = err;
        if (e2 >= dy) begin
            nxt_err  = nxt_err + dy;
            nxt_pt.x = sx ? cur.x + 16'sd1 : cur.x - 16'sd1;
        end
        if (e2 <= dx) begin
            nxt_err  = nxt_err + dx;
            nxt_pt.y = sy ? cur.y + 16'sd1 : cur.y - 16'sd1;
        end
    end

endmodule

// File: rtl/draw_line.sv
// Custom instruction that rasterises a line and issues one pixel write per
// on-screen point through the shared addr/data/wr/busy pixel port.
module draw_line
    import draw_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              wr,
    input  logic              busy,
    input  logic              clk_en,
    input  logic              start,
    input  logic              n,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result
);

    localparam logic signed [15:0] H_LIM = 16'(H_RES);
    localparam logic signed [15:0] V_LIM = 16'(V_RES);

    state_t             state_reg, state_next;
    logic [31:0]        colour_reg, colour_next;
    point_t             p1_reg, p1_next;
    point_t             cur_reg, cur_next;
    logic signed [17:0] dx_reg, dx_next;
    logic signed [17:0] dy_reg, dy_next;
    logic signed [17:0] err_reg, err_next;
    logic               sx_reg, sx_next;
    logic               sy_reg, sy_next;
    logic [31:0]        count_reg, count_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [31:0]        data_reg, data_next;
    logic               wr_reg, wr_next;
    logic               done_reg, done_next;
    logic [31:0]        result_reg, result_next;

    logic signed [17:0] diff_x, diff_y, abs_x, abs_y;
    logic               on_screen;
    logic [ADDR_W-1:0]  lin_addr;
    point_t             step_pt;
    logic signed [17:0] step_err;

    // Endpoint deltas are formed with two guard bits so no 16-bit pair overflows.
    assign diff_x = $signed({{2{p1_reg.x[15]}}, p1_reg.x}) - $signed({{2{cur_reg.x[15]}}, cur_reg.x});
    assign diff_y = $signed({{2{p1_reg.y[15]}}, p1_reg.y}) - $signed({{2{cur_reg.y[15]}}, cur_reg.y});
    assign abs_x  = diff_x[17] ? -diff_x : diff_x;
    assign abs_y  = diff_y[17] ? -diff_y : diff_y;

    assign on_screen = !cur_reg.x[15] && (cur_reg.x < H_LIM) &&
                       !cur_reg.y[15] && (cur_reg.y < V_LIM);
    // Only meaningful when on_screen; coordinates are then non-negative.
    assign lin_addr  = ADDR_W'({16'd0, cur_reg.x} + {16'd0, cur_reg.y} * 32'(H_RES));

    bresenham_step u_step (
        .cur     (cur_reg),
        .err     (err_reg),
        .dx      (dx_reg),
        .dy      (dy_reg),
        .sx      (sx_reg),
        .sy      (sy_reg),
        .nxt_pt  (step_pt),
        .nxt_err (step_err)
    );

    // State register; everything freezes while clk_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            colour_reg <= '0;
            p1_reg     <= '0;
            cur_reg    <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_reg     <= 1'b0;
            sy_reg     <= 1'b0;
            count_reg  <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            wr_reg     <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (clk_en) begin
            state_reg  <= state_next;
            colour_reg <= colour_next;
            p1_reg     <= p1_next;
            cur_reg    <= cur_next;
            dx_reg     <= dx_next;
            dy_reg     <= dy_next;
            err_reg    <= err_next;
            sx_reg     <= sx_next;
            sy_reg     <= sy_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            wr_reg     <= wr_next;
            done_reg   <= done_next;
            result_reg <= result_next;
        end
    end

    // Next-state and output logic; wr and done are single-cycle pulses by default.
    always_comb begin
        state_next  = state_reg;
        colour_next = colour_reg;
        p1_next     = p1_reg;
        cur_next    = cur_reg;
        dx_next     = dx_reg;
        dy_next     = dy_reg;
        err_next    = err_reg;
        sx_next     = sx_reg;
        sy_next     = sy_reg;
        count_next  = count_reg;
        addr_next   = addr_reg;
        data_next   = data_reg;
        result_next = result_reg;
        wr_next     = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && n == OP_SET_COLOR) begin
                    colour_next = dataa;
                    result_next = colour_reg;
                    done_next   = 1'b1;
                end else if (start && n == OP_DRAW) begin
                    cur_next   = to_point(dataa);
                    p1_next    = to_point(datab);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                dx_next    = abs_x;
                dy_next    = -abs_y;
                err_next   = abs_x - abs_y;
                sx_next    = !diff_x[17] && (diff_x != 18'sd0);
                sy_next    = !diff_y[17] && (diff_y != 18'sd0);
                count_next = '0;
                state_next = PLOT;
            end
            PLOT: begin
                // Off-screen points are skipped; on-screen ones wait for the memory path.
                if (!(on_screen && busy)) begin
                    if (on_screen) begin
                        wr_next    = 1'b1;
                        addr_next  = lin_addr;
                        data_next  = colour_reg;
                        count_next = count_reg + 32'd1;
                    end
                    state_next = (cur_reg == p1_reg) ? FINISH : STEP;
                end
            end
            STEP: begin
                cur_next   = step_pt;
                err_next   = step_err;
                state_next = PLOT;
            end
            FINISH: begin
                done_next   = 1'b1;
                result_next = count_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign addr   = addr_reg;
    assign data   = data_reg;
    assign wr     = wr_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_draw_line.sv
// Directed bench for draw_line: colour set, lines, backpressure, clipping,
// clock-enable stretching and mid-line reset.
module tb_draw_line;
    import draw_pkg::*;

    localparam int ADDR_W = 19;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              busy   = 1'b0;
    logic              clk_en = 1'b1;
    logic              start  = 1'b0;
    logic              n      = 1'b0;
    logic [31:0]       dataa  = '0;
    logic [31:0]       datab  = '0;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              wr;
    logic              done;
    logic [31:0]       result;

    int errors = 0;
    int checks = 0;

    // Stimulus modes for the input generator.
    logic bp_mode    = 1'b0;
    logic en_toggle  = 1'b0;
    logic busy_force = 1'b0;
    int   bp_cnt     = 0;
    logic busy_prev  = 1'b0;

    // Observed traffic.
    logic [ADDR_W-1:0] addr_q[$];
    logic [31:0]       data_q[$];
    int                done_cnt   = 0;
    logic [31:0]       last_result = '0;
    int                busy_viol  = 0;
    int                exp_q[$];

    draw_line dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .data   (data),
        .wr     (wr),
        .busy   (busy),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // busy and clk_en generator, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (wr) bp_cnt = 0;
            busy = (bp_cnt < 6);
            bp_cnt++;
        end else begin
            busy = busy_force;
        end
        clk_en = en_toggle ? ~clk_en : 1'b1;
    end

    always @(posedge clk) busy_prev <= busy;

    // Monitor: a strobe counts once, on the cycle whose edge is enabled.
    always @(negedge clk) begin
        if (clk_en) begin
            if (wr) begin
                addr_q.push_back(addr);
                data_q.push_back(data);
                if (busy_prev) busy_viol++;
            end
            if (done) begin
                done_cnt++;
                last_result = result;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pt(input int x, input int y);
        logic [31:0] w;
        w = {16'(y), 16'(x)};
        return w;
    endfunction

    // Present one instruction and hold start until an enabled edge takes it.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        do @(negedge clk); while (!clk_en);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic issue(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input int max_cycles);
        int   d0;
        logic ok;
        d0 = done_cnt;
        ok = 1'b0;
        send(op, a, b);
        for (int i = 0; i < max_cycles; i++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check({tag, " done"}, 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        check({tag, " done_once"}, 32'(done_cnt - d0), 32'd1);
        $display("%s: op=%0d dataa=0x%08h datab=0x%08h writes=%0d result=%0d",
                 tag, op, a, b, addr_q.size(), last_result);
    endtask

    // Compare captured writes against exp_q and the expected colour.
    task automatic check_writes(input string tag, input logic [31:0] colour);
        check({tag, " wr_count"}, 32'(addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), 32'(addr_q[i]), 32'(exp_q[i]));
            check($sformatf("%s data[%0d]", tag, i), data_q[i], colour);
        end
    endtask

    task automatic clear_capture();
        addr_q.delete();
        data_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int wr_before;
        int done_before;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset wr", 32'(wr), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset addr", 32'(addr), 32'd0);
        check("reset data", data, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Colour set, then a horizontal line.
        clear_capture();
        issue("set_color", OP_SET_COLOR, 32'h00FF00FF, 32'd0, 20);
        check("set_color result", last_result, 32'd0);
        check("set_color no wr", 32'(addr_q.size()), 32'd0);
        clear_capture();
        exp_q = '{0, 1, 2, 3};
        issue("hline", OP_DRAW, pt(0, 0), pt(3, 0), 200);
        check_writes("hline", 32'h00FF00FF);
        check("hline result", last_result, 32'd4);

        // Steep line.
        clear_capture();
        exp_q = '{6410, 7050, 7691, 8331, 8971};
        issue("steep", OP_DRAW, pt(10, 10), pt(11, 14), 200);
        check_writes("steep", 32'h00FF00FF);
        check("steep result", last_result, 32'd5);

        // Backpressure.
        clear_capture();
        busy_viol = 0;
        bp_cnt    = 0;
        bp_mode   = 1'b1;
        exp_q = '{3205, 3206, 3207};
        issue("backpressure", OP_DRAW, pt(5, 5), pt(7, 5), 400);
        bp_mode = 1'b0;
        check_writes("backpressure", 32'h00FF00FF);
        check("backpressure busy_viol", 32'(busy_viol), 32'd0);
        check("backpressure result", last_result, 32'd3);

        // Partial clipping.
        clear_capture();
        exp_q = '{306560, 306561};
        issue("clip_part", OP_DRAW, pt(-2, 479), pt(1, 479), 200);
        check_writes("clip_part", 32'h00FF00FF);
        check("clip_part result", last_result, 32'd2);

        // Fully off-screen.
        clear_capture();
        issue("clip_all", OP_DRAW, pt(700, 500), pt(705, 500), 200);
        check_writes("clip_all", 32'h00FF00FF);
        check("clip_all result", last_result, 32'd0);

        // Single point at the far corner.
        clear_capture();
        exp_q = '{307199};
        issue("corner", OP_DRAW, pt(639, 479), pt(639, 479), 200);
        check_writes("corner", 32'h00FF00FF);
        check("corner result", last_result, 32'd1);

        // New colour returns the previous one.
        clear_capture();
        issue("set_color2", OP_SET_COLOR, 32'h12345678, 32'd0, 20);
        check("set_color2 result", last_result, 32'h00FF00FF);

        // Same steep line with clk_en toggling every cycle.
        clear_capture();
        en_toggle = 1'b1;
        exp_q = '{6410, 7050, 7691, 8331, 8971};
        issue("steep_clken", OP_DRAW, pt(10, 10), pt(11, 14), 400);
        en_toggle = 1'b0;
        check_writes("steep_clken", 32'h12345678);
        check("steep_clken result", last_result, 32'd5);
        repeat (2) @(posedge clk);

        // Reset while the 10th pixel strobe is high.
        clear_capture();
        done_before = done_cnt;
        send(OP_DRAW, pt(0, 0), pt(100, 0));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() >= 10) break;
        end
        check("midreset reached 10", 32'(addr_q.size()), 32'd10);
        reset = 1'b0;
        #1;
        check("midreset wr", 32'(wr), 32'd0);
        check("midreset addr", 32'(addr), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        wr_before = addr_q.size();
        check("midreset no more wr", 32'(wr_before), 32'd10);
        check("midreset no done", 32'(done_cnt - done_before), 32'd0);
        $display("midreset: writes_before_reset=%0d", wr_before);

        // Fresh draw after reset uses the cleared colour.
        clear_capture();
        exp_q = '{2};
        issue("after_reset", OP_DRAW, pt(2, 0), pt(2, 0), 200);
        check_writes("after_reset", 32'd0);
        check("after_reset result", last_result, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
